// File: rtl/riscv_pkg.sv
// Shared RV32M definitions: divide-family aluSelect codes, default XLEN
// and the divider FSM state type.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [5:0] ALU_DIV  = 6'b101010;
  localparam logic [5:0] ALU_DIVU = 6'b101011;
  localparam logic [5:0] ALU_REM  = 6'b101100;
  localparam logic [5:0] ALU_REMU = 6'b101101;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} div_state_t;

  function automatic logic is_div_op(input logic [5:0] sel);
    return (sel == ALU_DIV) || (sel == ALU_DIVU) || (sel == ALU_REM) || (sel == ALU_REMU);
  endfunction

  function automatic logic op_is_signed(input logic [5:0] sel);
    return (sel == ALU_DIV) || (sel == ALU_REM);
  endfunction

  function automatic logic op_is_rem(input logic [5:0] sel);
    return (sel == ALU_REM) || (sel == ALU_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, trial-subtract the divisor, keep the difference when it is non-negative.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic         dividend_bit,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic         quotient_bit
);

  logic [W:0]   partial;
  logic [W-1:0] diff;

  // When the subtraction succeeds the difference is below the divisor, so
  // the low W bits carry the whole value.
  assign partial      = {rem, dividend_bit};
  assign quotient_bit = (partial >= {1'b0, divisor});
  assign diff         = partial[W-1:0] - divisor;
  assign rem_next     = quotient_bit ? diff : partial[W-1:0];

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer (restoring radix-2, XLEN steps).
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish in one cycle.
module div_sequencer
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            startValid,
  input  logic [5:0]      aluSelect,
  input  logic [XLEN-1:0] operandA,
  input  logic [XLEN-1:0] operandB,
  input  logic [4:0]      destReg,
  input  logic            flush,
  output logic            startReady,
  output logic            busy,
  output logic            resultValid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      resultRd
);

  localparam int CW = $clog2(XLEN);

  div_state_t      state_reg, state_next;
  logic [CW-1:0]   count_reg;
  logic [XLEN-1:0] dividend_reg, divisor_reg, rem_reg, a_raw_reg, result_reg;
  logic [4:0]      rd_reg, result_rd_reg;
  logic            op_rem_reg, neg_q_reg, neg_r_reg, b_zero_reg;

  logic            accept, early_out, op_signed, a_neg, b_neg, b_zero;
  logic [XLEN-1:0] abs_a, abs_b, fix_result, step_rem;
  logic            step_q;

  assign startReady  = (state_reg == IDLE) || (state_reg == DONE);
  assign busy        = (state_reg == ITER) || (state_reg == FIX);
  assign resultValid = (state_reg == DONE);
  assign result      = result_reg;
  assign resultRd    = result_rd_reg;

  assign accept    = startValid & startReady & ~flush & is_div_op(aluSelect);
  assign op_signed = op_is_signed(aluSelect);
  assign a_neg     = op_signed & operandA[XLEN-1];
  assign b_neg     = op_signed & operandB[XLEN-1];
  assign b_zero    = (operandB == '0);
  // Two's-complement negate leaves the most negative value unchanged, which
  // is exactly its magnitude as an unsigned number.
  assign abs_a     = a_neg ? (~operandA + 1'b1) : operandA;
  assign abs_b     = b_neg ? (~operandB + 1'b1) : operandB;

`ifdef DIV_EARLY_OUT_EN
  logic            overflow;
  logic [XLEN-1:0] early_result;

  assign overflow  = op_signed && (operandA == {1'b1, {(XLEN-1){1'b0}}}) && (operandB == '1);
  assign early_out = b_zero | overflow;

  always_comb begin
    early_result = '0;
    if (b_zero)
      early_result = op_is_rem(aluSelect) ? operandA : '1;
    else if (!op_is_rem(aluSelect))
      early_result = {1'b1, {(XLEN-1){1'b0}}};
  end
`else
  assign early_out = 1'b0;
`endif

  div_step #(.W(XLEN)) u_step (
    .rem          (rem_reg),
    .dividend_bit (dividend_reg[XLEN-1]),
    .divisor      (divisor_reg),
    .rem_next     (step_rem),
    .quotient_bit (step_q)
  );

  // After XLEN steps dividend_reg holds the unsigned quotient.
  always_comb begin
    fix_result = '0;
    if (b_zero_reg)
      fix_result = op_rem_reg ? a_raw_reg : '1;
    else if (op_rem_reg)
      fix_result = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;
    else
      fix_result = neg_q_reg ? (~dividend_reg + 1'b1) : dividend_reg;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (accept)
          state_next = early_out ? DONE : ITER;
        else if (state_reg == DONE)
          state_next = IDLE;
      end
      ITER: if (count_reg == CW'(XLEN - 1)) state_next = FIX;
      FIX:  state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg     <= '0;
      dividend_reg  <= '0;
      divisor_reg   <= '0;
      rem_reg       <= '0;
      a_raw_reg     <= '0;
      rd_reg        <= '0;
      op_rem_reg    <= 1'b0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
      b_zero_reg    <= 1'b0;
      result_reg    <= '0;
      result_rd_reg <= '0;
    end else if (accept) begin
      count_reg    <= '0;
      dividend_reg <= abs_a;
      divisor_reg  <= abs_b;
      rem_reg      <= '0;
      a_raw_reg    <= operandA;
      rd_reg       <= destReg;
      op_rem_reg   <= op_is_rem(aluSelect);
      neg_q_reg    <= op_signed & (operandA[XLEN-1] ^ operandB[XLEN-1]) & ~b_zero;
      neg_r_reg    <= a_neg;
      b_zero_reg   <= b_zero;
`ifdef DIV_EARLY_OUT_EN
      if (early_out) begin
        result_reg    <= early_result;
        result_rd_reg <= destReg;
      end
`endif
    end else if (state_reg == ITER) begin
      rem_reg      <= step_rem;
      dividend_reg <= {dividend_reg[XLEN-2:0], step_q};
      count_reg    <= count_reg + 1'b1;
    end else if (state_reg == FIX && !flush) begin
      result_reg    <= fix_result;
      result_rd_reg <= rd_reg;
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed table, corner sequences and
// random ops against an arithmetic reference model.
module tb_div_sequencer;

  localparam logic [5:0] OP_DIV  = 6'b101010;
  localparam logic [5:0] OP_DIVU = 6'b101011;
  localparam logic [5:0] OP_REM  = 6'b101100;
  localparam logic [5:0] OP_REMU = 6'b101101;
  localparam logic [5:0] OP_MUL  = 6'b100110;
  localparam int FULL_LAT = 33;

  logic        clk = 1'b0;
  logic        reset, startValid, flush;
  logic [5:0]  aluSelect;
  logic [31:0] operandA, operandB, result;
  logic [4:0]  destReg, resultRd;
  logic        startReady, busy, resultValid;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_sequencer dut (
    .clk(clk), .reset(reset), .startValid(startValid), .aluSelect(aluSelect),
    .operandA(operandA), .operandB(operandB), .destReg(destReg), .flush(flush),
    .startReady(startReady), .busy(busy), .resultValid(resultValid),
    .result(result), .resultRd(resultRd)
  );

  typedef struct {
    logic [5:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [5:0] sel, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return (sel == OP_REM || sel == OP_REMU) ? a : 32'hFFFF_FFFF;
    case (sel)
      OP_DIV:  return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
      OP_REM:  return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb);
      OP_DIVU: return a / b;
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [5:0] sel, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    if (b == 0) return 0;
    if ((sel == OP_DIV || sel == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
`endif
    return (sel == 6'h0 && a == b) ? FULL_LAT : FULL_LAT;
  endfunction

  task automatic issue(input logic [5:0] sel, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    startValid = 1'b1;
    aluSelect  = sel;
    operandA   = a;
    operandB   = b;
    destReg    = rd;
    @(posedge clk); #1;
    startValid = 1'b0;
    aluSelect  = 6'h0;
  endtask

  // Counts edges after acceptance until resultValid, plus busy cycles seen.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    forever begin
      if (busy) busy_cnt++;
      if (resultValid || lat >= 100) break;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [5:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int lat, bc, exp_lat;
    exp_lat = ref_latency(sel, a, b);
    issue(sel, a, b, rd);
    wait_done(lat, bc);
    $display("op %s sel=%b a=%h b=%h rd=%0d result=%h rd_out=%0d lat=%0d busy=%0d",
             tag, sel, a, b, rd, result, resultRd, lat, bc);
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".busy_cycles"}, bc, exp_lat);
    check({tag, ".result"}, result, exp);
    check({tag, ".rd"}, 32'(resultRd), 32'(rd));
    @(posedge clk); #1;
    check({tag, ".pulse_end"}, 32'(resultValid), 0);
  endtask

  task automatic watch_idle(input string tag, input int cycles);
    int pulses;
    int bc;
    pulses = 0;
    bc = 0;
    for (int i = 0; i < cycles; i++) begin
      if (resultValid) pulses++;
      if (busy) bc++;
      @(posedge clk); #1;
    end
    $display("idle %s pulses=%0d busy=%0d", tag, pulses, bc);
    check({tag, ".no_pulse"}, pulses, 0);
    check({tag, ".no_busy"}, bc, 0);
  endtask

  vec_t vecs[$];

  initial begin
    int lat, bc;
    logic [5:0]  sel;
    logic [31:0] a, b;
    logic [4:0]  rd;

    reset = 1'b1; startValid = 1'b0; flush = 1'b0;
    aluSelect = 6'h0; operandA = '0; operandB = '0; destReg = '0;

    vecs.push_back('{OP_DIVU, 32'd100,        32'd7,          5'd1,  32'd14});
    vecs.push_back('{OP_REMU, 32'd100,        32'd7,          5'd2,  32'd2});
    vecs.push_back('{OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD});
    vecs.push_back('{OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFF});
    vecs.push_back('{OP_DIV,  32'd7,          32'hFFFF_FFFE,  5'd5,  32'hFFFF_FFFD});
    vecs.push_back('{OP_REM,  32'd7,          32'hFFFF_FFFE,  5'd6,  32'd1});
    vecs.push_back('{OP_DIV,  32'd5,          32'd0,          5'd7,  32'hFFFF_FFFF});
    vecs.push_back('{OP_REMU, 32'd5,          32'd0,          5'd8,  32'd5});
    vecs.push_back('{OP_REM,  32'hFFFF_FFFB,  32'd0,          5'd9,  32'hFFFF_FFFB});
    vecs.push_back('{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'h8000_0000});
    vecs.push_back('{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'h0});
    vecs.push_back('{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd31, 32'hFFFF_FFFF});
    vecs.push_back('{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'h0});

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset.busy", 32'(busy), 0);
    check("reset.valid", 32'(resultValid), 0);
    check("reset.result", result, 0);
    check("reset.rd", 32'(resultRd), 0);
    check("reset.ready", 32'(startReady), 1);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp);

    // Flush on the tenth ITER cycle, then a fresh op must still complete.
    issue(OP_DIVU, 32'd1000, 32'd3, 5'd14);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    $display("flush_iter busy=%0d ready=%0d", busy, startReady);
    check("flush_iter.busy", 32'(busy), 0);
    check("flush_iter.ready", 32'(startReady), 1);
    watch_idle("flush_iter", 40);
    run_op("after_flush", OP_DIVU, 32'd9, 32'd3, 5'd15, 32'd3);

    // Flush in the acceptance cycle drops the op.
    flush = 1'b1;
    issue(OP_DIVU, 32'd50, 32'd5, 5'd16);
    flush = 1'b0;
    watch_idle("flush_accept", 40);

    // MUL code is not ours.
    issue(OP_MUL, 32'd6, 32'd7, 5'd17);
    watch_idle("mul_ignored", 40);

    // Back-to-back: second op accepted in the DONE cycle of the first.
    issue(OP_DIVU, 32'd100, 32'd7, 5'd5);
    wait_done(lat, bc);
    $display("b2b first result=%h rd=%0d lat=%0d", result, resultRd, lat);
    check("b2b.first_lat", lat, FULL_LAT);
    check("b2b.first_result", result, 32'd14);
    check("b2b.first_rd", 32'(resultRd), 5);
    check("b2b.ready_in_done", 32'(startReady), 1);
    issue(OP_DIVU, 32'd9, 32'd3, 5'd12);
    wait_done(lat, bc);
    $display("b2b second result=%h rd=%0d gap=%0d", result, resultRd, lat + 1);
    check("b2b.gap", lat + 1, 34);
    check("b2b.second_result", result, 32'd3);
    check("b2b.second_rd", 32'(resultRd), 12);
    @(posedge clk); #1;

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: sel = OP_DIV;
        1: sel = OP_DIVU;
        2: sel = OP_REM;
        default: sel = OP_REMU;
      endcase
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2, 3: b = $urandom_range(1, 20);
        4: b = 32'($urandom_range(1, 20)) * 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      rd = 5'($urandom_range(0, 31));
      run_op($sformatf("rnd%0d", n), sel, a, b, rd, ref_result(sel, a, b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle sequencer for the RV32M divide/remainder operations (DIV, DIVU, REM, REMU) in the execute stage. It accepts one operation at a time, runs a restoring radix-2 divide over XLEN iterations, and holds the pipeline through `busy` while the operation is in flight. It returns the quotient or remainder together with the destination-register tag. MUL-family codes stay in the single-cycle ALU; this block ignores them.

## Interface
- `XLEN`, 32, operand/result width; iteration count equals XLEN
- `clk` in 1, sole clock, rising edge
- `reset` in 1, synchronous, active-high
- `startValid` in 1, execute stage presents an operation this cycle
- `aluSelect` in 6, decoded op: 101010 DIV, 101011 DIVU, 101100 REM, 101101 REMU
- `operandA` in XLEN, dividend (rs1)
- `operandB` in XLEN, divisor (rs2)
- `destReg` in 5, rd tag, carried to `resultRd`
- `flush` in 1, kill any in-flight operation
- `startReady` out 1, the block will accept `startValid` this cycle
- `busy` out 1, stall request to the pipeline
- `resultValid` out 1, one-cycle pulse, `result`/`resultRd` valid
- `result` out XLEN, quotient or remainder
- `resultRd` out 5, rd of the completed operation

## Operation
- States: IDLE, ITER, FIX, DONE.
- Acceptance is `startValid & startReady & ~flush` with `aluSelect` set to one of the four codes. Any other code is ignored and causes no state change.
- `startReady` is high in IDLE and DONE, giving back-to-back issue.
- On acceptance, the block latches:
  - `|A|` and `|B|` as unsigned values; for signed ops, 0x80000000 maps to 0x80000000.
  - The op.
  - `destReg`.
  - The quotient-negate flag: signed op, sign(A) ≠ sign(B), and B ≠ 0.
  - The remainder-negate flag: signed op and A < 0.
- The iteration counter is cleared and the FSM enters ITER.
- ITER runs one restoring step per cycle:
  - remainder (XLEN+1 bits) = {rem, dividend MSB}
  - Trial-subtract the divisor.
  - If the difference is ≥ 0: keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - After XLEN steps, go to FIX.
- FIX applies the negate flags and special cases, registers `result`, and goes to DONE.
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give A unmodified.
  - Signed overflow (A = 0x80000000, B = 0xFFFFFFFF): DIV gives 0x80000000, REM gives 0. The abs/negate path produces this naturally.
- DONE asserts `resultValid` for one cycle, then returns to IDLE, or to ITER if a new op is accepted in the same cycle.
- `flush` or `reset` in any state: the next edge returns the FSM to IDLE with no `resultValid`.
  - A flush in the acceptance cycle wins, and the op is dropped.
  - A flush during DONE suppresses nothing, because the pulse is already visible.
- Reset values: `busy` 0, `resultValid` 0, `result` 0, `resultRd` 0, `startReady` 1, state IDLE, counter 0.

## Timing
- Acceptance at edge E gives ITER during E+1..E+32, FIX at E+33, and `resultValid` high in the cycle after edge E+33. Latency is 34 cycles with `XLEN` = 32.
- `busy` is high in ITER and FIX only, and low in IDLE and DONE.
- `result` and `resultRd` are registered and hold their value until the next completion.
- All outputs are driven from registers or state decode only; there is no combinational path from input to output except through `startReady`.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - An accepted op with B = 0, or with DIV/REM and A = 0x80000000, B = 0xFFFFFFFF, goes directly IDLE → DONE.
  - The result is registered at edge E, and `resultValid` is high in the cycle after E.
  - `busy` never asserts for these ops.
- `DIV_EARLY_OUT_EN` undefined: every op takes the full 34-cycle path, and FIX produces identical results.

## Structure
- Shared package `riscv_pkg`:
  - `aluSelect` code constants (DIV/DIVU/REM/REMU)
  - `XLEN` default
  - the `div_state_t` enum (IDLE, ITER, FIX, DONE)
- Sub-module `div_step`: one combinational restoring iteration.
  - Inputs: remainder, next dividend bit, divisor.
  - Outputs: new remainder, quotient bit.
- FSM, counter and sign fix-up live in `div_sequencer`.

## Test plan
- DIVU 100 / 7 → `result` 14 after 34 cycles; REMU 100 / 7 → 2; `busy` high for exactly 33 cycles.
- DIV −7 / 2 → 0xFFFFFFFD (−3); REM −7 / 2 → 0xFFFFFFFF (−1); DIV 7 / −2 → −3.
- DIV 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5; DIV 0x80000000 / −1 → 0x80000000, REM → 0. With `DIV_EARLY_OUT_EN`, each has 1-cycle latency and `busy` stays 0.
- `flush` at cycle 10 of ITER → no `resultValid`, IDLE next cycle; a new DIVU 9 / 3 then completes with 3.
- Back-to-back ops: the second op is accepted in the DONE cycle of the first. Check two `resultValid` pulses 34 cycles apart, and that `resultRd` follows each op's `destReg` (5, then 12).
- `aluSelect` = MUL (100110) with `startValid` → ignored: `busy` 0 and no `resultValid`.
